// File: rtl/serial_pkg.sv
// serial_pkg: receiver FSM states, register offsets and STATUS bit positions
// shared by the serial blocks.
package serial_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
    localparam logic [2:0] SERIAL_RX_DATA   = 3'd0;
    localparam logic [2:0] SERIAL_RX_STATUS = 3'd4;
    localparam int ST_NE   = 0;
    localparam int ST_FULL = 1;
    localparam int ST_FERR = 2;
    localparam int ST_OVR  = 3;
    localparam int ST_CNT  = 4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [NW-1:0] count_q;
    logic do_push, do_pop;
    always_comb begin
        empty   = count_q == '0;
        full    = count_q == NW'(DEPTH);
        do_pop  = pop & !empty;
        do_push = push & (!full | do_pop);
        dout    = mem_q[rd_q];
        count   = count_q;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + NW'(do_push) - NW'(do_pop);
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/serial_rx.sv
// serial_rx: memory-mapped 8N1 UART receiver with a byte FIFO drained through
// DATA reads, plus sticky framing-error/overrun flags cleared by STATUS reads.
module serial_rx import serial_pkg::*; #(
    parameter int CLK_HZ = 10000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    input  logic        sel,
    input  logic        re,
    input  logic [2:0]  addr,
    output logic [31:0] dout,
    output logic        irq
);
    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int NW   = $clog2(DEPTH + 1);
    logic [1:0] sync_q;
    rx_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d, head;
    logic ferr_q, ferr_d, ovr_q, ovr_d, irq_q, irq_d;
    logic rxs, expired, push_req, set_ferr, push, pop, clr, is_status, full, empty, unused;
    logic [NW-1:0] count;
    logic [31:0] status;
    assign unused = ^addr[1:0];
    assign rxs = sync_q[1];
    assign expired = cnt_q == '0;
    always_comb begin
        state_d  = state_q;
        cnt_d    = expired ? cnt_q : cnt_q - 1'b1;
        bit_d    = bit_q;
        sh_d     = sh_q;
        push_req = 1'b0;
        set_ferr = 1'b0;
        case (state_q)
            IDLE: if (!rxs) begin
                cnt_d   = CW'(HALF - 1);
                state_d = START;
            end
            START: if (expired) begin
                cnt_d   = CW'(DIV - 1);
                bit_d   = '0;
                state_d = rxs ? IDLE : DATA;
            end
            DATA: if (expired) begin
                sh_d    = {rxs, sh_q[7:1]};
                cnt_d   = CW'(DIV - 1);
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (expired) begin
                push_req = rxs;
                set_ferr = !rxs;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Overrun only when the frame is dropped; a same-cycle pop frees a slot.
    always_comb begin
        is_status = addr[2] == SERIAL_RX_STATUS[2];
        pop       = sel & re & !is_status & !empty;
        clr       = sel & re & is_status;
        push      = push_req & (!full | pop);
        ovr_d     = (push_req & full & !pop) | (ovr_q & !clr);
        ferr_d    = set_ferr | (ferr_q & !clr);
        irq_d     = push | (count > NW'(pop));
        status    = '0;
        status[ST_NE]        = !empty;
        status[ST_FULL]      = full;
        status[ST_FERR]      = ferr_q;
        status[ST_OVR]       = ovr_q;
        status[ST_CNT +: 5]  = 5'(count);
        dout      = is_status ? status : (empty ? 32'b0 : {1'b1, 23'b0, head});
        irq       = irq_q;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            irq_q   <= irq_d;
        end
    end
    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (sh_q),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: drives 8N1 frames from a UART line model and checks register
// reads against a queue-based model of the receive FIFO and sticky flags.
module tb_serial_rx;
    localparam int DIV   = 86;
    localparam int DEPTH = 16;
    logic clock = 0, reset = 0, rx = 1, sel = 0, re = 0;
    logic [2:0] addr = 0;
    logic [31:0] dout;
    logic irq;
    int checks = 0, fails = 0;
    logic [7:0] model_q[$];
    bit m_ferr = 0, m_ovr = 0;

    serial_rx dut (.clock(clock), .reset(reset), .rx(rx), .sel(sel), .re(re),
                   .addr(addr), .dout(dout), .irq(irq));

    always #5 clock = ~clock;

    function automatic logic [31:0] model_status();
        return {23'b0, 5'(model_q.size()), m_ovr, m_ferr,
                model_q.size() == DEPTH, model_q.size() != 0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        @(posedge clock); #1 rx = 0;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(posedge clock);
            #1 rx = b[i];
        end
        repeat (DIV) @(posedge clock); #1 rx = stop_ok;
        repeat (DIV) @(posedge clock); #1 rx = 1;
        if (!stop_ok) m_ferr = 1;
        else if (model_q.size() == DEPTH) m_ovr = 1;
        else model_q.push_back(b);
        if (!stop_ok) repeat (100) @(posedge clock);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clock);
        sel = 1; re = 1; addr = a;
        #1 d = dout;
        @(posedge clock);
        #1 sel = 0; re = 0;
    endtask

    task automatic test_reset();
        addr = 3'd0; #1;
        checks++; if (dout !== 32'h0) begin fails++; $display("FAIL reset_data got=%h exp=%h", dout, 32'h0); end
        addr = 3'd4; #1;
        checks++; if (dout !== 32'h0) begin fails++; $display("FAIL reset_status got=%h exp=%h", dout, 32'h0); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(posedge clock); #1 reset = 1;
        repeat (5) @(posedge clock);
    endtask

    task automatic test_basic();
        logic [31:0] d, exp;
        send_frame(8'h55, 1);
        send_frame(8'hA3, 1);
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL basic_irq_high got=%b exp=1", irq); end
        exp = model_status();
        bus_read(3'd4, d); m_ferr = 0; m_ovr = 0;
        checks++; if (d !== 32'h21 || exp !== 32'h21) begin fails++; $display("FAIL basic_status got=%h exp=%h", d, 32'h21); end
        bus_read(3'd0, d); void'(model_q.pop_front());
        checks++; if (d !== 32'h80000055) begin fails++; $display("FAIL basic_data0 got=%h exp=%h", d, 32'h80000055); end
        bus_read(3'd0, d); void'(model_q.pop_front());
        checks++; if (d !== 32'h800000A3) begin fails++; $display("FAIL basic_data1 got=%h exp=%h", d, 32'h800000A3); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL basic_irq_low got=%b exp=0", irq); end
    endtask

    task automatic test_glitch();
        logic [31:0] d, exp;
        @(posedge clock); #1 rx = 0;
        repeat (20) @(posedge clock); #1 rx = 1;
        repeat (100) @(posedge clock);
        exp = model_status();
        bus_read(3'd4, d); m_ferr = 0; m_ovr = 0;
        checks++; if (d !== exp) begin fails++; $display("FAIL glitch_status got=%h exp=%h", d, exp); end
        send_frame(8'($urandom), 1);
        exp = {1'b1, 23'b0, model_q.pop_front()};
        bus_read(3'd0, d);
        checks++; if (d !== exp) begin fails++; $display("FAIL glitch_after_data got=%h exp=%h", d, exp); end
    endtask

    task automatic test_ferr();
        logic [31:0] d, exp;
        send_frame(8'h7E, 0);
        exp = model_status();
        bus_read(3'd4, d); m_ferr = 0; m_ovr = 0;
        checks++; if (d !== 32'h4 || exp !== 32'h4) begin fails++; $display("FAIL ferr_status got=%h exp=%h", d, 32'h4); end
        bus_read(3'd4, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL ferr_cleared got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_random();
        logic [31:0] d, exp;
        for (int i = 0; i < 6; i++) send_frame(8'($urandom), $urandom_range(0, 3) != 0);
        exp = model_status();
        bus_read(3'd4, d); m_ferr = 0; m_ovr = 0;
        checks++; if (d !== exp) begin fails++; $display("FAIL random_status got=%h exp=%h", d, exp); end
        while (model_q.size() != 0) begin
            exp = {1'b1, 23'b0, model_q.pop_front()};
            bus_read(3'd0, d);
            checks++; if (d !== exp) begin fails++; $display("FAIL random_data got=%h exp=%h", d, exp); end
        end
        bus_read(3'd0, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL random_empty_pop got=%h exp=%h", d, 32'h0); end
        bus_read(3'd4, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL random_status_end got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, exp;
        for (int i = 0; i < DEPTH + 1; i++) send_frame(8'($urandom), 1);
        exp = model_status();
        bus_read(3'd4, d); m_ferr = 0; m_ovr = 0;
        checks++; if (d !== 32'h10B || exp !== 32'h10B) begin fails++; $display("FAIL ovf_status got=%h exp=%h", d, 32'h10B); end
        for (int i = 0; i < DEPTH; i++) begin
            exp = {1'b1, 23'b0, model_q.pop_front()};
            bus_read(3'd0, d);
            checks++; if (d !== exp) begin fails++; $display("FAIL ovf_data%0d got=%h exp=%h", i, d, exp); end
        end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL ovf_irq got=%b exp=0", irq); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d, dp, exp, expp;
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1);
        b = 8'($urandom);
        fork
            send_frame(b, 1);
            begin
                @(posedge clock);
                repeat (819) @(posedge clock);
                expp = {1'b1, 23'b0, model_q.pop_front()};
                bus_read(3'd0, dp);
            end
        join
        checks++; if (dp !== expp) begin fails++; $display("FAIL pp_pop_data got=%h exp=%h", dp, expp); end
        exp = model_status();
        bus_read(3'd4, d); m_ferr = 0; m_ovr = 0;
        checks++; if (d !== 32'h103 || exp !== 32'h103) begin fails++; $display("FAIL pp_status got=%h exp=%h", d, 32'h103); end
        for (int i = 0; i < DEPTH; i++) begin
            exp = {1'b1, 23'b0, model_q.pop_front()};
            bus_read(3'd0, d);
            checks++; if (d !== exp) begin fails++; $display("FAIL pp_data%0d got=%h exp=%h", i, d, exp); end
        end
        checks++; if (exp !== {24'h800000, b}) begin fails++; $display("FAIL pp_last_order got=%h exp=%h", exp, {24'h800000, b}); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d, exp;
        logic [7:0] b;
        send_frame(8'h5A, 1);
        b = 8'hC6;
        @(posedge clock); #1 rx = 0;
        for (int i = 0; i < 5; i++) begin
            repeat (DIV) @(posedge clock);
            #1 rx = b[i];
        end
        repeat (DIV / 2) @(posedge clock);
        #1 reset = 0; rx = 1;
        model_q.delete(); m_ferr = 0; m_ovr = 0;
        repeat (5) @(posedge clock);
        #1 reset = 1;
        repeat (200) @(posedge clock);
        bus_read(3'd4, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL mid_reset_status got=%h exp=%h", d, 32'h0); end
        send_frame(8'h31, 1);
        exp = model_status();
        bus_read(3'd4, d); m_ferr = 0; m_ovr = 0;
        checks++; if (d !== 32'h11 || exp !== 32'h11) begin fails++; $display("FAIL mid_status got=%h exp=%h", d, 32'h11); end
        bus_read(3'd0, d); void'(model_q.pop_front());
        checks++; if (d !== 32'h80000031) begin fails++; $display("FAIL mid_data got=%h exp=%h", d, 32'h80000031); end
        bus_read(3'd4, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL mid_final_status got=%h exp=%h", d, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_ferr();
        test_random();
        test_overflow();
        test_push_pop_full();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
